pong_game_ctrl: RTL and testbench

//  Top-level game sequencer for Pong. Sits between vga_sync and the graphics/text units.

---
 rtl/pong_game_ctrl_if.sv | 38 +++
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong game-controller bus.
// Groups the signals that pass between the game sequencer and its neighbours:
//   pixel_x, pixel_y  10  pixel counters from vga_sync
//   btn               2   paddle buttons (level, active-high)
//   hit, miss         1   1-clk pulses from the graphics unit
//   frame_tick        1   1-clk pulse once per frame
//   graph_still       1   hold the ball stationary and centred
//   ball_serve        1   1-clk pulse: reload ball position/velocity
//   game_state        2   00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//   dig1, dig0        4   score in BCD (tens, ones)
//   lives_left        2   balls remaining
// Modports:
//   master - the game sequencer (drives the status/control outputs)
//   slave  - the surrounding sync/graphics/text units
interface pong_game_ctrl_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       frame_tick;
    logic       graph_still;
    logic       ball_serve;
    logic [1:0] game_state;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [1:0] lives_left;

    modport master (
        input  pixel_x, pixel_y, btn, hit, miss,
        output frame_tick, graph_still, ball_serve, game_state, dig1, dig0, lives_left
    );

    modport slave (
        output pixel_x, pixel_y, btn, hit, miss,
        input  frame_tick, graph_still, ball_serve, game_state, dig1, dig0, lives_left
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer.
// Derives a once-per-frame tick from the vga_sync pixel counters, runs the
// NEWGAME/PLAY/NEWBALL/OVER game FSM, keeps a two-digit BCD score and the
// remaining ball count, and tells the graphics unit when to freeze and when
// to re-serve the ball.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    pong_game_ctrl_if.master (pixel counters, buttons, hit/miss in;
//          frame_tick, graph_still, ball_serve, game_state, score, lives out)
// The FSM state is visible directly on bus.game_state.
module pong_game_ctrl #(
    parameter int LIVES       = 3,    // 1..3
    parameter int WAIT_FRAMES = 120,  // 1..255
    parameter int TICK_Y      = 481
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_NEWGAME = 2'b00,
        S_PLAY    = 2'b01,
        S_NEWBALL = 2'b10,
        S_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] WAIT_INIT  = 8'(WAIT_FRAMES);
    localparam logic [9:0] TICK_ROW   = 10'(TICK_Y);

    state_t     state, state_n;
    logic [3:0] dig1, dig0, dig1_n, dig0_n;
    logic [1:0] lives, lives_n;
    logic [7:0] timer, timer_n;
    logic       match, match_d, frame_tick;
    logic [1:0] btn_d;
    logic       btn_rise, timer_up;
    logic       graph_still, ball_serve;

    // The pixel counters dwell on (0,TICK_Y) for several clocks, so only the
    // first clock of the match produces a tick.
    assign match    = (bus.pixel_x == 10'd0) && (bus.pixel_y == TICK_ROW);
    assign btn_rise = |(bus.btn & ~btn_d);
    assign timer_up = (timer == 8'd0);

    // btn_d comes out of reset as "already pressed": a button that is held
    // through reset release must be let go and pressed again to count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_d    <= 1'b0;
            frame_tick <= 1'b0;
            btn_d      <= 2'b11;
        end else begin
            match_d    <= match;
            frame_tick <= match & ~match_d;
            btn_d      <= bus.btn;
        end
    end

    always_comb begin
        state_n = state;
        dig1_n  = dig1;
        dig0_n  = dig0;
        lives_n = lives;
        timer_n = timer;
        if (frame_tick && !timer_up)
            timer_n = timer - 8'd1;
        case (state)
            S_NEWGAME: begin
                if (btn_rise)
                    state_n = S_PLAY;
            end
            S_PLAY: begin
                // A miss takes priority; a coincident hit is dropped.
                if (bus.miss) begin
                    lives_n = lives - 2'd1;
                    timer_n = WAIT_INIT;
                    state_n = (lives == 2'd1) ? S_OVER : S_NEWBALL;
                end else if (bus.hit) begin
                    if (dig0 == 4'd9) begin
                        dig0_n = 4'd0;
                        dig1_n = (dig1 == 4'd9) ? 4'd0 : dig1 + 4'd1;
                    end else begin
                        dig0_n = dig0 + 4'd1;
                    end
                end
            end
            S_NEWBALL: begin
                if (timer_up && btn_rise)
                    state_n = S_PLAY;
            end
            S_OVER: begin
                if (timer_up) begin
                    state_n = S_NEWGAME;
                    dig1_n  = 4'd0;
                    dig0_n  = 4'd0;
                    lives_n = LIVES_INIT;
                end
            end
            default: state_n = S_NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_NEWGAME;
            dig1        <= 4'd0;
            dig0        <= 4'd0;
            lives       <= LIVES_INIT;
            timer       <= 8'd0;
            graph_still <= 1'b1;
            ball_serve  <= 1'b0;
        end else begin
            state       <= state_n;
            dig1        <= dig1_n;
            dig0        <= dig0_n;
            lives       <= lives_n;
            timer       <= timer_n;
            graph_still <= (state_n != S_PLAY);
            ball_serve  <= (state_n == S_PLAY) && (state != S_PLAY);
        end
    end

    assign bus.frame_tick  = frame_tick;
    assign bus.graph_still = graph_still;
    assign bus.ball_serve  = ball_serve;
    assign bus.game_state  = state;
    assign bus.dig1        = dig1;
    assign bus.dig0        = dig0;
    assign bus.lives_left  = lives;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: drives pixel counters, buttons and hit/miss
// pulses, and compares the controller against a game-level model (integer
// score, lives and frame countdown).
module tb_pong_game_ctrl;
    localparam int WAIT_F = 120;
    localparam int LIVES  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(.LIVES(LIVES), .WAIT_FRAMES(WAIT_F), .TICK_Y(481)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- game model ----------------
    // states: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
    int         m_state, m_score, m_lives, m_timer;
    logic       m_serve;
    logic [1:0] m_prev;

    function automatic logic [12:0] model_vec();
        return {2'(m_state), 4'(m_score / 10), 4'(m_score % 10), 2'(m_lives), (m_state != 1)};
    endfunction

    logic [12:0] dut_vec;
    assign dut_vec = {bus.game_state, bus.dig1, bus.dig0, bus.lives_left, bus.graph_still};

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_lives = LIVES; m_timer = 0; m_serve = 1'b0;
    endfunction

    function automatic void model_clk(input logic h, input logic m, input logic [1:0] b);
        logic rise;
        rise    = |(b & ~m_prev);
        m_prev  = b;
        m_serve = 1'b0;
        case (m_state)
            0: if (rise) begin m_state = 1; m_serve = 1'b1; end
            1: begin
                if (m) begin
                    m_lives = m_lives - 1;
                    m_timer = WAIT_F;
                    m_state = (m_lives == 0) ? 3 : 2;
                end else if (h) begin
                    m_score = (m_score + 1) % 100;
                end
            end
            2: if (rise && m_timer == 0) begin m_state = 1; m_serve = 1'b1; end
            default: ;
        endcase
    endfunction

    function automatic void model_frame();
        m_serve = 1'b0;
        if (m_timer > 0) m_timer = m_timer - 1;
        if (m_state == 3 && m_timer == 0) begin
            m_state = 0; m_score = 0; m_lives = LIVES;
        end
    endfunction

    // ---------------- frame tick scoreboard ----------------
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    always @(negedge clk)
        if (bus.frame_tick) obs_q.push_back({bus.pixel_x, bus.pixel_y});

    // ---------------- driver tasks ----------------
    // One transaction: inputs applied for one clock, hit/miss then released.
    // Returns 1 time unit after the edge that consumed the inputs.
    task automatic step(input logic h, input logic m, input logic [1:0] b);
        @(posedge clk); #1;
        bus.hit = h; bus.miss = m; bus.btn = b;
        model_clk(h, m, b);
        @(posedge clk); #1;
        bus.hit = 1'b0; bus.miss = 1'b0;
    endtask

    // Compressed frame: only the dwell on (0,481) matters to the controller.
    task automatic short_frame();
        @(posedge clk); #1;
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd481;
        @(posedge clk);
        @(posedge clk); #1;
        bus.pixel_x = 10'd1;
        @(posedge clk); #1;
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd0;
        @(posedge clk);
        @(posedge clk); #1;
        model_frame();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) short_frame();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        m_prev = bus.btn;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd0; bus.btn = 2'b00;
        bus.hit = 1'b0; bus.miss = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({dut_vec, bus.ball_serve, bus.frame_tick} !== {model_vec(), 2'b00}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", {dut_vec, bus.ball_serve, bus.frame_tick}, {model_vec(), 2'b00});
        end
        #1 reset = 1'b0;
        m_prev = 2'b00;
    endtask

    task automatic test_frame_tick();
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 2; f++)
            for (int y = 480; y <= 482; y++)
                for (int x = 0; x < 800; x++) begin
                    @(posedge clk); #1;
                    bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
                    if (x == 0 && y == 481) exp_q.push_back({10'd0, 10'd481});
                    @(posedge clk);
                end
        @(posedge clk); #1;
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd0;
        repeat (2) @(posedge clk); #1;
        total++;
        if (obs_q.size() != 2) begin
            bad++;
            $display("FAIL tick_count: got %0d want %0d", obs_q.size(), 2);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [19:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL tick_position: got x=%0d y=%0d want x=%0d y=%0d", o[19:10], o[9:0], e[19:10], e[9:0]);
            end
        end
        total++;
        if (dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL idle_after_sweep: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_serve_and_hits();
        logic [1:0] b;
        b = 2'($urandom_range(1, 2));
        step(1'b0, 1'b0, b);
        total++;
        if ({dut_vec, bus.ball_serve} !== {model_vec(), 1'b1} || m_state != 1) begin
            bad++;
            $display("FAIL serve_entry: got %h want %h", {dut_vec, bus.ball_serve}, {model_vec(), 1'b1});
        end
        step(1'b0, 1'b0, 2'b00);
        total++;
        if (bus.ball_serve !== 1'b0) begin
            bad++;
            $display("FAIL serve_one_clk: got %b want 0", bus.ball_serve);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 2'b00);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h08 || dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL eight_hits: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_bcd();
        int n;
        n = (9 - m_score + 100) % 100;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h10 || dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL carry_09_10: got %h want %h", dut_vec, model_vec());
        end
        n = (99 - m_score + 100) % 100;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h99) begin
            bad++;
            $display("FAIL reach_99: got %h%h want 99", bus.dig1, bus.dig0);
        end
        step(1'b1, 1'b0, 2'b00);
        total++;
        if ({bus.dig1, bus.dig0} !== 8'h00 || dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL wrap_99_00: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_newball();
        step(1'b1, 1'b1, 2'b00);
        total++;
        if (dut_vec !== model_vec() || m_state != 2 || m_lives != 2) begin
            bad++;
            $display("FAIL miss_beats_hit: got %h want %h", dut_vec, model_vec());
        end
        step(1'b1, 1'b0, 2'b00);
        total++;
        if (dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL hit_ignored_newball: got %h want %h", dut_vec, model_vec());
        end
        frames(50);
        step(1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 2'b00);
        total++;
        if (dut_vec !== model_vec() || m_state != 2) begin
            bad++;
            $display("FAIL early_btn_50: got %h want %h", dut_vec, model_vec());
        end
        frames(WAIT_F - 51);
        step(1'b0, 1'b0, 2'b10);
        step(1'b0, 1'b0, 2'b00);
        total++;
        if (dut_vec !== model_vec() || m_state != 2) begin
            bad++;
            $display("FAIL early_btn_119: got %h want %h", dut_vec, model_vec());
        end
        frames(1);
        step(1'b0, 1'b0, 2'b01);
        total++;
        if ({dut_vec, bus.ball_serve} !== {model_vec(), m_serve} || m_state != 1) begin
            bad++;
            $display("FAIL reserve_120: got %h want %h", {dut_vec, bus.ball_serve}, {model_vec(), m_serve});
        end
        step(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_over();
        step(1'b0, 1'b1, 2'b00);
        frames(WAIT_F);
        step(1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        total++;
        if (dut_vec !== model_vec() || m_state != 3 || m_lives != 0) begin
            bad++;
            $display("FAIL enter_over: got %h want %h", dut_vec, model_vec());
        end
        step(1'b1, 1'b0, 2'b00);
        obs_q.delete();
        frames(WAIT_F - 1);
        total++;
        if (dut_vec !== model_vec() || m_state != 3) begin
            bad++;
            $display("FAIL over_hold_119: got %h want %h", dut_vec, model_vec());
        end
        frames(1);
        total++;
        if (dut_vec !== model_vec() || m_state != 0 || m_lives != LIVES) begin
            bad++;
            $display("FAIL over_to_newgame: got %h want %h", dut_vec, model_vec());
        end
        total++;
        if (obs_q.size() != WAIT_F) begin
            bad++;
            $display("FAIL over_tick_count: got %0d want %0d", obs_q.size(), WAIT_F);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 2'b10);
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        frames(30);
        @(posedge clk); #1 bus.btn = 2'b01;
        @(negedge clk); #2 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({dut_vec, bus.ball_serve, bus.frame_tick} !== {model_vec(), 2'b00}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", {dut_vec, bus.ball_serve, bus.frame_tick}, {model_vec(), 2'b00});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_prev = bus.btn;
        repeat (5) @(posedge clk); #1;
        total++;
        if (dut_vec !== model_vec() || bus.ball_serve !== 1'b0) begin
            bad++;
            $display("FAIL held_btn_no_play: got %h want %h", dut_vec, model_vec());
        end
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b01);
        total++;
        if ({dut_vec, bus.ball_serve} !== {model_vec(), 1'b1} || m_state != 1) begin
            bad++;
            $display("FAIL repress_play: got %h want %h", {dut_vec, bus.ball_serve}, {model_vec(), 1'b1});
        end
        step(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: step(1'b1, 1'b0, 2'b00);
                2:    step(1'b0, 1'b1, 2'b00);
                3:    step(1'b1, 1'b1, 2'b00);
                4: begin
                    step(1'b0, 1'b0, 2'($urandom_range(1, 3)));
                    total++;
                    if (bus.ball_serve !== m_serve) begin
                        bad++;
                        $display("FAIL rand_serve[%0d]: got %b want %b", i, bus.ball_serve, m_serve);
                    end
                    step(1'b0, 1'b0, 2'b00);
                end
                default: frames($urandom_range(1, 60));
            endcase
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL rand_op[%0d] op=%0d: got %h want %h", i, op, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_serve_and_hits();
        test_bcd();
        test_newball();
        test_over();
        test_reset_mid();
        test_random();
        apply_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
